bitrev_pp: RTL and testbench
============================

# bitrev_pp

Ping-pong bit-reversal reorder buffer with a run-time selectable frame length (2^k words, 1 ≤ k ≤ KMAX) and a per-frame bypass mode. Each bank has full/empty tracking, so the block supports true back-pressure on both sides and marks the last word of each output frame. It sits between the FFT butterfly stages and the next consumer. It accepts natural-order frames and emits them in k-bit-reversed order, or in natural order when bypassed.

## Interface
- KMAX, 10, log2 of the largest frame; each bank holds 2^KMAX words
- DW, 32, data width per sample
- KW, $clog2(KMAX+1), width of cfg_k_i (derived, not overridden)

- clk_i  in  1  single clock, all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- cfg_k_i  in  KW  log2 frame length for the next frame; 0 is treated as 1, values >KMAX are treated as KMAX
- cfg_bypass_i  in  1  1 = next frame is passed through in natural order
- valid_i  in  1  write-side sample valid
- data_i  in  DW  write-side sample
- ready_o  out  1  write-side ready
- valid_o  out  1  read-side sample valid
- data_o  out  DW  read-side sample (registered)
- last_o  out  1  high with the final word of each output frame
- ready_i  in  1  read-side ready
- busy_o  out  1  high while any bank is not EMPTY or valid_o is high

## Operation
- Storage is two banks, A and B, of 2^KMAX words each (behavioural array). Each bank holds a state EMPTY / FILLING / FULL, plus a latched k_b and bypass_b.
- Write pointer wr_bank and read pointer rd_bank start at A. Counters wr_cnt and rd_cnt are KMAX bits wide.
- ready_o = !rst_i && state[wr_bank] != FULL.
- A write is accepted on (valid_i && ready_o).
  - First accept into an EMPTY bank: latch the clamped cfg_k_i and cfg_bypass_i into the bank; state becomes FILLING.
  - Every accept: write mem[wr_bank][wr_cnt], then wr_cnt++.
  - On the accept with wr_cnt == 2^k_b − 1: state becomes FULL, wr_cnt = 0, wr_bank toggles.
- Changes to cfg_k_i or cfg_bypass_i mid-frame have no effect until the next frame starts.
- A read is issued when state[rd_bank] == FULL && (!valid_o || ready_i). On issue:
  - Address = bypass_b ? rd_cnt : rev_k(rd_cnt). rev_k reverses bits [k_b−1:0]; upper address bits are 0.
  - data_o ← mem[rd_bank][addr], valid_o ← 1, last_o ← (rd_cnt == 2^k_b − 1).
  - rd_cnt++. On the last word: state becomes EMPTY, rd_cnt = 0, rd_bank toggles.
- Output stall: if valid_o && ready_i and no read can be issued, valid_o ← 0 and last_o ← 0. If valid_o && !ready_i, data_o, last_o and valid_o hold.
- Simultaneous events:
  - A read from one bank and a write into the other proceed in the same cycle.
  - A bank released to EMPTY by a read on edge t accepts its first write on edge t+1. ready_o rises combinationally after edge t.
- Both banks FULL: ready_o = 0 until the reader releases one.
- Reset (any cycle, including mid-frame): all banks EMPTY, wr_bank = rd_bank = A, counters 0, valid_o = 0, last_o = 0, data_o = 0, busy_o = 0, ready_o = 0 during reset. Contents are discarded. Stored data is not cleared.

## Timing
- Latency: last word of a frame accepted at edge t → first output word registered at edge t+1, so valid_o is high in cycle t+1.
- Throughput is 1 word/clock per side in steady state. Alternating frames sustain 100% with no bubbles when ready_i is held at 1.
- data_o, valid_o and last_o are registered. ready_o and busy_o are combinational from state registers only; there is no path from valid_i to ready_o.
- The handshake is AXI-stream-like: once valid_o is high, data_o and last_o stay stable until ready_i is seen.

## Test plan
- k=3, no bypass, input 0..7 with valid_i and ready_i held at 1 → output 0,4,2,6,1,5,3,7. last_o is high only on 7. First valid_o appears one cycle after input 7 is accepted.
- Back-to-back frames (k=3, inputs 0..7 then 8..15, ready_i=1) → ready_o stays 1 throughout. Output is 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15 with no gaps.
- ready_i=0 throughout, stream k=2 frames → after 8 accepts (both banks FULL) ready_o=0. valid_o holds word 0 stable. Raising ready_i drains 0,2,1,3,4,6,5,7, and ready_o reasserts the cycle after bank A is released.
- Frame 1 with k=2, bypass=0; frame 2 with k=4, bypass=1; cfg toggled mid-frame → frame 1 outputs 0,2,1,3. Frame 2 outputs 16 words in natural order; the mid-frame cfg changes are ignored.
- cfg_k_i=0 and cfg_k_i=15 with KMAX=10 → frame lengths of 2 and 1024 words respectively. last_o is high on the 2nd and 1024th output words.
- rst_i asserted for 1 cycle after 5 of 8 words have been written and 1 word is pending on the output → next cycle valid_o=0, busy_o=0, ready_o=1. A fresh k=3 frame 0..7 then outputs the correct reversed order.

Source files
------------

// File: rtl/bitrev_pp.sv
`default_nettype none
// ============================================================================
//  Module      : bitrev_pp
//  Description : Ping-pong bit-reversal reorder buffer. Two banks of 2^KMAX
//                words alternate between being filled in natural order and
//                drained in k-bit-reversed (or natural, when bypassed) order.
//                Frame length and bypass are latched per bank at the first
//                word of each frame. Full back-pressure on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitrev_pp #(
    parameter  int KMAX = 10,
    parameter  int DW   = 32,
    localparam int KW   = $clog2(KMAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [KW-1:0] cfg_k_i,
    input  logic          cfg_bypass_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    input  logic          ready_i,
    output logic          busy_o
);

    localparam int C_DEPTH = 1 << KMAX;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } bank_state_t;

    // Index of the final word of a 2^k frame, expressed on the counter width.
    function automatic logic [KMAX-1:0] f_last_idx(input logic [KW-1:0] k);
        logic [KMAX:0] l_span;
        l_span     = (KMAX+1)'(1) << k;
        f_last_idx = KMAX'(l_span - (KMAX+1)'(1));
    endfunction

    // Storage: bank select is the MSB of the address.
    logic [DW-1:0]        r_mem [0:2*C_DEPTH-1];

    bank_state_t          r_state     [2];
    bank_state_t          w_state_nxt [2];
    logic [1:0][KW-1:0]   r_k, w_k_nxt;
    logic [1:0]           r_byp, w_byp_nxt;
    logic                 r_wr_bank, w_wr_bank_nxt;
    logic                 r_rd_bank, w_rd_bank_nxt;
    logic [KMAX-1:0]      r_wr_cnt, w_wr_cnt_nxt;
    logic [KMAX-1:0]      r_rd_cnt, w_rd_cnt_nxt;

    logic                 r_valid;
    logic                 r_last;
    logic [DW-1:0]        r_data;

    logic [KW-1:0]        w_cfg_k;
    logic [KW-1:0]        w_wr_k;
    logic                 w_wr_accept;
    logic                 w_wr_last;
    logic [KW-1:0]        w_rd_k;
    logic [KW-1:0]        w_rd_shift;
    logic [KMAX-1:0]      w_rev_full;
    logic [KMAX-1:0]      w_rd_addr;
    logic                 w_rd_issue;
    logic                 w_rd_last;

    // Clamp the requested frame length into 1..KMAX.
    assign w_cfg_k = (cfg_k_i == '0)          ? KW'(1)    :
                     (cfg_k_i > KW'(KMAX))    ? KW'(KMAX) : cfg_k_i;

    // A fresh bank takes its length from the live config; otherwise the latched one.
    assign w_wr_k      = (r_state[r_wr_bank] == ST_EMPTY) ? w_cfg_k : r_k[r_wr_bank];
    assign ready_o     = !rst_i && (r_state[r_wr_bank] != ST_FULL);
    assign w_wr_accept = valid_i && ready_o;
    assign w_wr_last   = (r_wr_cnt == f_last_idx(w_wr_k));

    // Full-width reversal of the read counter; shifting right by KMAX-k
    // leaves the k-bit reversal since counter bits above k-1 are zero.
    for (genvar gi = 0; gi < KMAX; gi++) begin : g_rev
        assign w_rev_full[gi] = r_rd_cnt[KMAX-1-gi];
    end

    assign w_rd_k     = r_k[r_rd_bank];
    assign w_rd_shift = KW'(KMAX) - w_rd_k;
    assign w_rd_addr  = r_byp[r_rd_bank] ? r_rd_cnt : (w_rev_full >> w_rd_shift);
    assign w_rd_issue = (r_state[r_rd_bank] == ST_FULL) && (!r_valid || ready_i);
    assign w_rd_last  = (r_rd_cnt == f_last_idx(w_rd_k));

    // Bank bookkeeping register: states, latched config, pointers, counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= '{ST_EMPTY, ST_EMPTY};
            r_k       <= '0;
            r_byp     <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_byp     <= w_byp_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_wr_cnt  <= w_wr_cnt_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
        end
    end

    // Next-state logic; the writer never touches a FULL bank and the reader
    // only touches a FULL one, so both updates can be applied independently.
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_byp_nxt     = r_byp;
        w_wr_bank_nxt = r_wr_bank;
        w_rd_bank_nxt = r_rd_bank;
        w_wr_cnt_nxt  = r_wr_cnt;
        w_rd_cnt_nxt  = r_rd_cnt;

        if (w_wr_accept) begin
            if (r_state[r_wr_bank] == ST_EMPTY) begin
                w_k_nxt[r_wr_bank]     = w_cfg_k;
                w_byp_nxt[r_wr_bank]   = cfg_bypass_i;
                w_state_nxt[r_wr_bank] = ST_FILLING;
            end
            if (w_wr_last) begin
                w_state_nxt[r_wr_bank] = ST_FULL;
                w_wr_cnt_nxt           = '0;
                w_wr_bank_nxt          = ~r_wr_bank;
            end else begin
                w_wr_cnt_nxt = r_wr_cnt + KMAX'(1);
            end
        end

        if (w_rd_issue) begin
            if (w_rd_last) begin
                w_state_nxt[r_rd_bank] = ST_EMPTY;
                w_rd_cnt_nxt           = '0;
                w_rd_bank_nxt          = ~r_rd_bank;
            end else begin
                w_rd_cnt_nxt = r_rd_cnt + KMAX'(1);
            end
        end
    end

    // Sample storage; contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (w_wr_accept) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= data_i;
        end
    end

    // Registered output stage with hold-while-stalled behaviour.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (w_rd_issue) begin
            r_data  <= r_mem[{r_rd_bank, w_rd_addr}];
            r_valid <= 1'b1;
            r_last  <= w_rd_last;
        end else if (ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign last_o  = r_last;
    assign busy_o  = !rst_i && ((r_state[0] != ST_EMPTY) ||
                                (r_state[1] != ST_EMPTY) || r_valid);

endmodule
`default_nettype wire

// File: tb/tb_bitrev_pp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitrev_pp
//  Description : Self-checking bench for bitrev_pp: table vectors, directed
//                corner sequences and randomized frames against a frame-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitrev_pp;

    localparam int KMAX = 10;
    localparam int DW   = 32;
    localparam int KW   = $clog2(KMAX + 1);

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [KW-1:0] cfg_k_i = '0;
    logic          cfg_bypass_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          ready_i = 1'b0;
    logic          busy_o;

    always #5 clk = ~clk;

    bitrev_pp #(.KMAX(KMAX), .DW(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_k_i      (cfg_k_i),
        .cfg_bypass_i (cfg_bypass_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          last;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            rdy_pct  = 100;

    word_t         exp_q [$];
    word_t         got_q [$];
    int            got_cyc [$];
    logic [DW-1:0] m_words [$];
    int            m_k;
    logic          m_byp;

    vec_t          tbl [16];
    int            rev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    // Reference: reverse the low k bits of j arithmetically.
    function automatic int rev_bits(input int j, input int k);
        int r = 0;
        for (int b = 0; b < k; b++)
            if (((j >> b) & 1) != 0) r = r | (1 << (k - 1 - b));
        return r;
    endfunction

    function automatic int clamp_k(input int c);
        if (c == 0) return 1;
        if (c > KMAX) return KMAX;
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level model: latch config on the first word, emit the reordered
    // frame into the expectation queue once 2^k words have been collected.
    task automatic model_accept(input logic [DW-1:0] d);
        word_t w;
        int    n;
        int    a;
        if (m_words.size() == 0) begin
            m_k   = clamp_k(int'(cfg_k_i));
            m_byp = cfg_bypass_i;
        end
        m_words.push_back(d);
        n = 1 << m_k;
        if (m_words.size() == n) begin
            for (int j = 0; j < n; j++) begin
                a   = m_byp ? j : rev_bits(j, m_k);
                w.d = m_words[a];
                w.l = (j == n - 1);
                exp_q.push_back(w);
            end
            m_words.delete();
        end
    endtask

    // One clock: drive at the falling edge, score the handshakes that the
    // coming rising edge will complete, then wait for the next falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d);
        word_t g;
        word_t e;
        valid_i = v;
        data_i  = d;
        ready_i = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
        if (!rst_i) begin
            if (valid_o && ready_i) begin
                g.d = data_o;
                g.l = last_o;
                got_q.push_back(g);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got data %0h, expected no output", data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", data_o, e.d);
                    chk("out_last", last_o, e.l);
                end
            end
            if (valid_i && ready_o) model_accept(data_i);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_word(input logic [DW-1:0] d, output int tries);
        logic acc = 1'b0;
        tries = 0;
        while (!acc && tries < 3000) begin
            acc = ready_o;
            cycle(1'b1, d);
            tries++;
        end
        valid_i = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: word %0h not accepted, expected acceptance", d);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 6000) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk);
        cyc++;
        chk("rst_ready_low", ready_o, 0);
        chk("rst_busy_low", busy_o, 0);
        rst_i = 1'b0;
        exp_q.delete();
        m_words.delete();
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        int nlast;
        int gap_bad;
        int exp4 [20];
        int r3 [4] = '{0, 0, 0, 1};
        int exp3 [8] = '{0, 2, 1, 3, 4, 6, 5, 7};

        for (int i = 0; i < 16; i++) begin
            tbl[i].din  = DW'(i);
            tbl[i].dout = DW'(((i < 8) ? 0 : 8) + rev8[i % 8]);
            tbl[i].last = (i == 7) || (i == 15);
        end

        @(negedge clk);
        do_reset();
        chk("reset_valid", valid_o, 0);
        chk("reset_last", last_o, 0);
        chk("reset_data", data_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_ready", ready_o, 1);

        // Single k=3 frame, latency of first output.
        rdy_pct = 100;
        cfg_k_i = 4'd3; cfg_bypass_i = 1'b0;
        got_q.delete();
        for (int i = 0; i < 8; i++) push_word(tbl[i].din, tries);
        chk("latency_edge_t", valid_o, 0);
        cycle(1'b0, '0);
        chk("latency_edge_t1_valid", valid_o, 1);
        chk("latency_edge_t1_data", data_o, 0);
        drain();
        chk("k3_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            chk("k3_tbl_data", got_q[i].d, tbl[i].dout);
            chk("k3_tbl_last", got_q[i].l, tbl[i].last);
        end

        // Back-to-back frames: no input stalls, no output gaps.
        do_reset();
        got_q.delete(); got_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            push_word(tbl[i].din, tries);
            chk("b2b_ready_first_try", tries, 1);
        end
        drain();
        chk("b2b_count", got_q.size(), 16);
        gap_bad = 0;
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            chk("b2b_tbl_data", got_q[i].d, tbl[i].dout);
            chk("b2b_tbl_last", got_q[i].l, tbl[i].last);
            if (got_cyc[i] - got_cyc[0] != i) gap_bad++;
        end
        chk("b2b_no_gaps", gap_bad, 0);

        // Both banks full with ready_i low, then drain.
        do_reset();
        got_q.delete();
        rdy_pct = 0;
        cfg_k_i = 4'd2;
        for (int i = 0; i < 8; i++) push_word(DW'(i), tries);
        chk("full_ready_low", ready_o, 0);
        chk("full_valid_held", valid_o, 1);
        chk("full_data_word0", data_o, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0);
            chk("stall_data_stable", data_o, 0);
            chk("stall_valid_stable", valid_o, 1);
            chk("stall_last_stable", last_o, 0);
        end
        rdy_pct = 100;
        for (int i = 0; i < 4; i++) begin
            chk("ready_reassert", ready_o, r3[i]);
            cycle(1'b0, '0);
        end
        drain();
        chk("drain_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk("drain_order", got_q[i].d, exp3[i]);

        // Per-frame config latch with mid-frame changes.
        do_reset();
        got_q.delete();
        exp4[0] = 0; exp4[1] = 2; exp4[2] = 1; exp4[3] = 3;
        for (int i = 0; i < 16; i++) exp4[4 + i] = 16 + i;
        cfg_k_i = 4'd2; cfg_bypass_i = 1'b0;
        push_word(DW'(0), tries);
        cfg_k_i = 4'd4; cfg_bypass_i = 1'b1;
        for (int i = 1; i < 4; i++) push_word(DW'(i), tries);
        for (int i = 0; i < 16; i++) begin
            push_word(DW'(16 + i), tries);
            cfg_k_i = (i % 2 == 0) ? 4'd1 : 4'd3;
            cfg_bypass_i = (i % 2 == 0);
        end
        drain();
        chk("cfg_count", got_q.size(), 20);
        for (int i = 0; i < 20 && i < got_q.size(); i++)
            chk("cfg_order", got_q[i].d, exp4[i]);

        // Clamped lengths: 0 -> 2 words, 15 -> 1024 words, random ready.
        do_reset();
        got_q.delete();
        rdy_pct = 70;
        cfg_k_i = 4'd0; cfg_bypass_i = 1'b0;
        push_word(DW'('h500), tries);
        push_word(DW'('h501), tries);
        cfg_k_i = 4'd15;
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(4) == 0) cycle(1'b0, '0);
            push_word(DW'('h1000 + i), tries);
        end
        drain();
        chk("clamp_count", got_q.size(), 1026);
        nlast = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i].l) nlast++;
        chk("clamp_last_count", nlast, 2);
        if (got_q.size() == 1026) begin
            chk("clamp_last_k0", got_q[1].l, 1);
            chk("clamp_last_k15", got_q[1025].l, 1);
        end

        // Reset mid-frame with a pending output word.
        do_reset();
        rdy_pct = 0;
        cfg_k_i = 4'd3; cfg_bypass_i = 1'b0;
        for (int i = 0; i < 13; i++) push_word(DW'('h700 + i), tries);
        chk("pre_rst_valid", valid_o, 1);
        do_reset();
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_ready", ready_o, 1);
        rdy_pct = 100;
        got_q.delete();
        for (int i = 0; i < 8; i++) push_word(DW'(i), tries);
        drain();
        chk("post_rst_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk("post_rst_order", got_q[i].d, rev8[i]);

        // Randomized frames against the model.
        for (int f = 0; f < 30; f++) begin
            int n;
            rdy_pct      = $urandom_range(30, 100);
            cfg_k_i      = KW'($urandom_range(0, 6));
            cfg_bypass_i = $urandom_range(1);
            n = 1 << clamp_k(int'(cfg_k_i));
            for (int w = 0; w < n; w++) begin
                if (w > 0 && $urandom_range(3) == 0) begin
                    cfg_k_i      = KW'($urandom_range(0, 15));
                    cfg_bypass_i = $urandom_range(1);
                end
                if ($urandom_range(4) == 0) cycle(1'b0, '0);
                push_word($urandom, tries);
            end
        end
        drain();
        cycle(1'b0, '0);
        chk("final_busy", busy_o, 0);
        chk("final_valid", valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
